// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - key FIFO and command sequencer in front of the calc datapath
module calc_cmd_sequencer #(
    parameter int          DEPTH   = 8,
    parameter int          TIMEOUT = 255,
    parameter logic [3:0]  NOP_CMD = 4'd15,
    parameter logic [3:0]  CLR_CMD = 4'd14
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    output logic                           key_ready,
    input  logic [1:0]                     status,
    output logic [3:0]                     cmd,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic                           seq_busy,
    output logic                           err_calc,
    output logic                           err_timeout,
    output logic                           err_ovf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    state_t        state_q;
    logic [3:0]    cmd_q;
    logic [TW-1:0] timer_q;
    logic          err_calc_q;
    logic          err_timeout_q;
    logic          err_ovf_q;

    logic          full;
    logic          empty;
    logic [3:0]    head;
    logic          wait_err;
    logic          wait_to;
    logic          flush;
    logic          push;
    logic          pop;
    logic          bypass_clr;
    logic          clr_issue;
    logic          ovf;

    // Handshake and queue control derived from registered state only
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        head       = mem_q[rd_ptr_q];
        key_ready  = !full && (state_q != ST_ERROR);
        wait_err   = (state_q == ST_WAIT) && status[1];
        wait_to    = (state_q == ST_WAIT) && (status == 2'b01) && (timer_q >= TW'(TIMEOUT - 1));
        flush      = wait_err || wait_to;
        // A key handshaked in the flush cycle is dropped together with the queue.
        push       = key_valid && key_ready && !flush;
        pop        = (state_q == ST_IDLE) && !empty;
        bypass_clr = (state_q == ST_ERROR) && key_valid && (key_code == CLR_CMD);
        clr_issue  = (pop && (head == CLR_CMD)) || bypass_clr;
        // Keys arriving in ERROR are ignored silently, not counted as overflow.
        ovf        = key_valid && full && (state_q != ST_ERROR);
    end

    // Occupancy next-state: flush dominates, simultaneous push/pop cancels
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_code;
        end
    end

    // FIFO pointers and count; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Sequencer FSM with registered cmd pulse, wait timer and sticky fault flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_q         <= NOP_CMD;
            timer_q       <= '0;
            err_calc_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            cmd_q <= NOP_CMD;
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        cmd_q   <= head;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (status == 2'b00) begin
                        state_q <= ST_IDLE;
                    end else if (status[1]) begin
                        state_q <= ST_ERROR;
                    end else if (wait_to) begin
                        state_q <= ST_IDLE;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (bypass_clr) begin
                        cmd_q   <= CLR_CMD;
                        state_q <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Clearing happens on the issue edge; a flag raised on that same edge survives.
            err_calc_q    <= (err_calc_q    && !clr_issue) || wait_err;
            err_timeout_q <= (err_timeout_q && !clr_issue) || wait_to;
            err_ovf_q     <= (err_ovf_q     && !clr_issue) || ovf;
        end
    end

    assign cmd         = cmd_q;
    assign fifo_count  = count_q;
    assign seq_busy    = (state_q != ST_IDLE) || !empty;
    assign err_calc    = err_calc_q;
    assign err_timeout = err_timeout_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - directed scoreboard bench for calc_cmd_sequencer
module tb_calc_cmd_sequencer;

    localparam logic [3:0] NOP = 4'd15;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [1:0] status;
    logic [3:0] cmd;
    logic [3:0] fifo_count;
    logic       seq_busy;
    logic       err_calc;
    logic       err_timeout;
    logic       err_ovf;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         max_count = 0;
    int         t0;
    int         last_issue;
    logic [3:0] prev_cmd = NOP;
    logic [3:0] exp_q [$];
    int         issue_cyc [$];

    calc_cmd_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .status      (status),
        .cmd         (cmd),
        .fifo_count  (fifo_count),
        .seq_busy    (seq_busy),
        .err_calc    (err_calc),
        .err_timeout (err_timeout),
        .err_ovf     (err_ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge, cmd pulses checked against the scoreboard
    task automatic step();
        logic [3:0] e;
        @(posedge clock);
        cyc++;
        #1;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        if (cmd !== NOP) begin
            issue_cyc.push_back(cyc);
            chk(prev_cmd, NOP, "pulse_width");
            if (exp_q.size() == 0) begin
                chk(cmd, NOP, "cmd_unexpected");
            end else begin
                e = exp_q.pop_front();
                chk(cmd, e, "cmd_order");
            end
        end
        prev_cmd = cmd;
    endtask

    task automatic send(input logic [3:0] code, input logic exp_rdy, input logic enq);
        key_valid = 1'b1;
        key_code  = code;
        chk(key_ready, exp_rdy, "key_ready");
        if (enq) exp_q.push_back(code);
        step();
        key_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) step();
        chk(exp_q.size(), 0, "drain_timeout");
    endtask

    initial begin
        logic [3:0] fill [7];
        fill = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11};

        // reset values
        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; status = 2'b00;
        step(); step();
        chk(cmd, NOP, "rst_cmd");
        chk(fifo_count, 0, "rst_count");
        chk(key_ready, 1, "rst_key_ready");
        chk(seq_busy, 0, "rst_busy");
        chk({err_calc, err_timeout, err_ovf}, 0, "rst_flags");
        reset = 1'b0;

        // back-to-back 3,10,4,13 with calc always ready
        max_count = 0;
        issue_cyc.delete();
        t0 = cyc;
        send(4'd3, 1, 1); send(4'd10, 1, 1); send(4'd4, 1, 1); send(4'd13, 1, 1);
        drain(40);
        last_issue = cyc;
        chk(issue_cyc.size(), 4, "t1_issue_count");
        if (issue_cyc.size() >= 4) begin
            chk(issue_cyc[0], t0 + 2, "t1_latency");
            chk(issue_cyc[1] - issue_cyc[0], 3, "t1_gap1");
            chk(issue_cyc[2] - issue_cyc[1], 3, "t1_gap2");
            chk(issue_cyc[3] - issue_cyc[2], 3, "t1_gap3");
        end
        chk(max_count, 3, "t1_peak_count");
        step();
        chk(seq_busy, 1, "t1_busy_in_wait");
        step();
        chk(seq_busy, 0, "t1_busy_drop");
        chk(cyc, last_issue + 2, "t1_busy_drop_cycle");

        // overflow with calc busy: one key issued and stuck, eight fill the FIFO, next is dropped
        status = 2'b01;
        for (int k = 1; k <= 9; k++) send(4'(k), 1, 1);
        chk(fifo_count, 8, "t2_full_count");
        send(4'd12, 0, 0);
        chk(err_ovf, 1, "t2_err_ovf");
        chk(fifo_count, 8, "t2_count_after_drop");
        status = 2'b00;
        drain(60);
        send(4'd14, 1, 1);
        drain(10);
        chk(err_ovf, 0, "t2_clr_via_fifo");
        step(); step();
        chk(seq_busy, 0, "t2_idle");

        // calc error: flush, ERROR, ignored key, clear bypass
        status = 2'b10;
        send(4'd5, 1, 1); send(4'd6, 1, 0); send(4'd7, 1, 0); send(4'd8, 1, 0);
        chk(err_calc, 1, "t3_err_calc");
        chk(fifo_count, 0, "t3_flushed");
        chk(key_ready, 0, "t3_key_ready_err");
        chk(seq_busy, 1, "t3_busy_err");
        status = 2'b00;
        send(4'd7, 0, 0);
        chk(err_ovf, 0, "t3_no_ovf_in_error");
        chk(fifo_count, 0, "t3_key_ignored");
        send(4'd14, 0, 1);
        chk(err_calc, 0, "t3_err_cleared");
        step(); step();
        chk(seq_busy, 0, "t3_back_idle");
        chk(key_ready, 1, "t3_key_ready_idle");

        // hung calc: timeout after 255 wait cycles, queue flushed
        status = 2'b01;
        send(4'd2, 1, 1); send(4'd3, 1, 0); send(4'd4, 1, 0);
        repeat (254) step();
        chk(err_timeout, 0, "t4_not_yet");
        chk(fifo_count, 2, "t4_queued");
        step();
        chk(err_timeout, 1, "t4_err_timeout");
        chk(fifo_count, 0, "t4_flushed");
        chk(seq_busy, 0, "t4_idle");
        repeat (3) step();
        status = 2'b00;

        // simultaneous push and pop with wrapped pointers
        status = 2'b01;
        send(4'd6, 1, 1);
        for (int k = 0; k < 7; k++) send(fill[k], 1, 1);
        chk(fifo_count, 7, "t5_fill");
        status = 2'b00;
        step();
        send(4'd13, 1, 1);
        chk(fifo_count, 7, "t5_push_pop_count");
        drain(80);
        repeat (3) step();
        chk(fifo_count, 0, "t5_empty");
        chk(seq_busy, 0, "t5_idle");

        // reset during SETTLE with four queued
        status = 2'b01;
        send(4'd1, 1, 1); send(4'd2, 1, 1);
        send(4'd3, 1, 0); send(4'd4, 1, 0); send(4'd5, 1, 0); send(4'd6, 1, 0);
        chk(fifo_count, 5, "t6_fill");
        status = 2'b00;
        step(); step();
        chk(fifo_count, 4, "t6_queued_in_settle");
        reset = 1'b1;
        #1;
        chk(cmd, NOP, "t6_rst_cmd");
        chk(fifo_count, 0, "t6_rst_count");
        chk(key_ready, 1, "t6_rst_key_ready");
        chk(seq_busy, 0, "t6_rst_busy");
        chk({err_calc, err_timeout, err_ovf}, 0, "t6_rst_flags");
        step(); step();
        reset = 1'b0;
        repeat (10) step();
        chk(exp_q.size(), 0, "t6_no_reissue");
        chk(fifo_count, 0, "t6_count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
